// File: rtl/system_widths_pkg.sv
// System-wide bus widths shared by the MIU, its arbiter and the requesters.
package system_widths_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
endpackage

// File: rtl/miu_arbiter_sva.sv
// Protocol properties for miu_arbiter, attached to every instance through bind.
module miu_arbiter_sva #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = system_widths_pkg::ADDR_W
) (
  input logic               clk_i,
  input logic               resetN_i,
  input logic [NUM_REQ-1:0] rq_done_i,
  input logic               m_req_i,
  input logic               m_done_i,
  input logic               in_wait_i,
  input logic [ADDR_W-1:0]  m_addr_i
);
  a_done_onehot: assert property (@(posedge clk_i) disable iff (!resetN_i) $onehot0(rq_done_i));

  a_req_pulse: assert property (@(posedge clk_i) disable iff (!resetN_i) m_req_i |=> !m_req_i);

  a_addr_stable: assert property (@(posedge clk_i) disable iff (!resetN_i)
    (in_wait_i && $past(in_wait_i)) |-> $stable(m_addr_i));

  // An m_done arriving outside WAIT is ignored by the arbiter but is still an MIU protocol error.
  a_done_in_wait: assert property (@(posedge clk_i) disable iff (!resetN_i) m_done_i |-> in_wait_i);
endmodule

bind miu_arbiter miu_arbiter_sva #(.NUM_REQ(NUM_REQ)) u_sva (
  .clk_i    (clk),
  .resetN_i (resetN),
  .rq_done_i(rq_done),
  .m_req_i  (m_req),
  .m_done_i (m_done),
  .in_wait_i(state_q == WAIT),
  .m_addr_i (m_addr)
);

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 any_req_o
);
  localparam int IW = $clog2(N);

  logic [IW:0] cand;

  assign any_req_o = |req_i;

  // Walk the search order backwards so the requester closest to ptr_i is written last and wins.
  always_comb begin
    gnt_idx_o = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      if (req_i[cand[IW-1:0]]) gnt_idx_o = cand[IW-1:0];
    end
  end
endmodule

// File: rtl/miu_arbiter.sv
// Shares the single MIU request port between NUM_REQ requesters, round-robin,
// one transaction in flight; responses are routed back to the winner only.
module miu_arbiter
  import system_widths_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic [NUM_REQ-1:0]             rq_req,
  input  logic [NUM_REQ-1:0]             rq_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] rq_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] rq_write,
  output logic [NUM_REQ-1:0]             rq_done,
  output logic [DATA_W-1:0]              rq_read,
  output logic                           m_req,
  output logic                           m_we,
  output logic [ADDR_W-1:0]              m_addr,
  output logic [DATA_W-1:0]              m_write,
  input  logic                           m_done,
  input  logic [DATA_W-1:0]              m_read,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
);
  localparam int IW = $clog2(NUM_REQ);

  // Handshake: rq_req is a level held until the requester's 1-cycle rq_done; m_req and m_done
  // are 1-cycle pulses with exactly one MIU transaction outstanding between them.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_write_q, m_write_d;
  logic [NUM_REQ-1:0]  rq_done_q, rq_done_d;
  logic [DATA_W-1:0]   rq_read_q, rq_read_d;
  logic [IW-1:0]       win_idx;
  logic                any_req;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i    (rq_req),
    .ptr_i    (rr_ptr_q),
    .gnt_idx_o(win_idx),
    .any_req_o(any_req)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    m_req_d   = 1'b0;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_write_d = m_write_q;
    rq_done_d = '0;
    rq_read_d = rq_read_q;
    case (state_q)
      IDLE: begin
        // Capture the winner's request so later changes on its rq_* lines cannot leak through.
        if (any_req) begin
          grant_d   = win_idx;
          m_we_d    = rq_we[win_idx];
          m_addr_d  = rq_addr[win_idx];
          m_write_d = rq_write[win_idx];
          m_req_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (m_done) begin
          rq_done_d[grant_q] = 1'b1;
          if (!m_we_q) rq_read_d = m_read;
          rr_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_write_q <= '0;
      rq_done_q <= '0;
      rq_read_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_write_q <= m_write_d;
      rq_done_q <= rq_done_d;
      rq_read_q <= rq_read_d;
    end
  end

  assign rq_done  = rq_done_q;
  assign rq_read  = rq_read_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_write  = m_write_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
endmodule

// File: tb/tb_miu_arbiter.sv
// Bench for miu_arbiter: requester agent, MIU model with 0..5 cycle response delay,
// and a round-robin reference model feeding an expected-response queue.
module tb_miu_arbiter;
  import system_widths_pkg::*;

  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic                      clk = 1'b0;
  logic                      resetN = 1'b0;
  logic [N-1:0]              rq_req, rq_we, rq_done;
  logic [N-1:0][ADDR_W-1:0]  rq_addr;
  logic [N-1:0][DATA_W-1:0]  rq_write;
  logic [DATA_W-1:0]         rq_read, m_write, m_read;
  logic                      m_req, m_we, m_done, busy;
  logic [ADDR_W-1:0]         m_addr;
  logic [IW-1:0]             grant_id;

  miu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .resetN(resetN), .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr),
    .rq_write(rq_write), .rq_done(rq_done), .rq_read(rq_read), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_write(m_write), .m_done(m_done), .m_read(m_read), .busy(busy),
    .grant_id(grant_id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int reset_epoch = 0;

  task automatic reset_dut();
    @(posedge clk); #1;
    resetN = 1'b0;
    reset_epoch++;
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus configuration (written by the main sequence only).
  int                       target[N];
  bit                       rand_fields = 1'b0;
  bit                       scramble    = 1'b0;
  int                       raise_pct   = 100;
  int                       force_lat   = -1;
  int                       force_rd    = -1;
  logic [N-1:0]             nx_we;
  logic [N-1:0][ADDR_W-1:0] nx_addr;
  logic [N-1:0][DATA_W-1:0] nx_wr;

  // Agent bookkeeping (written by the agent only).
  int issued[N];

  // MIU handoff (written by the monitor only).
  int               miu_lat  = 0;
  logic [DATA_W-1:0] miu_data = '0;

  // Scoreboard / reference model state (written by the monitor only).
  logic [15:0]      exp_q[$];
  int               grant_log[$];
  int               m_ptr = 0;
  logic [DATA_W-1:0] model_read = '0;

  // ---------------- requester agent ----------------
  initial begin : agent
    logic [N-1:0] done_last;
    int seen_epoch;
    rq_req = '0; rq_we = '0; rq_addr = '0; rq_write = '0;
    done_last = '0; seen_epoch = 0;
    for (int i = 0; i < N; i++) issued[i] = 0;
    forever begin
      @(posedge clk); #2;
      if (seen_epoch != reset_epoch) begin
        seen_epoch = reset_epoch;
        rq_req = '0;
        done_last = '0;
        for (int i = 0; i < N; i++) issued[i] = target[i];
      end else begin
        for (int i = 0; i < N; i++) begin
          if (done_last[i]) begin
            rq_req[i] = 1'b0;
          end else if (!rq_req[i] && issued[i] < target[i] && int'($urandom_range(0, 99)) < raise_pct) begin
            issued[i]++;
            rq_req[i] = 1'b1;
            if (rand_fields) begin
              rq_we[i]    = 1'($urandom_range(0, 1));
              rq_addr[i]  = ADDR_W'($urandom);
              rq_write[i] = DATA_W'($urandom);
            end else begin
              rq_we[i]    = nx_we[i];
              rq_addr[i]  = nx_addr[i];
              rq_write[i] = nx_wr[i];
            end
          end else if (scramble && rq_req[i] && busy && int'(grant_id) == i) begin
            rq_addr[i]  = ADDR_W'($urandom);
            rq_write[i] = DATA_W'($urandom);
          end
        end
        done_last = rq_done;
      end
    end
  end

  // ---------------- MIU model ----------------
  initial begin : miu
    int lat, ep;
    logic [DATA_W-1:0] dat;
    m_done = 1'b0;
    m_read = '0;
    forever begin
      @(negedge clk);
      if (resetN && m_req) begin
        ep = reset_epoch;
        @(posedge clk);
        lat = miu_lat;
        dat = miu_data;
        repeat (lat) @(posedge clk);
        #1;
        if (ep == reset_epoch) begin
          m_done = 1'b1;
          m_read = dat;
          @(posedge clk); #1;
          m_done = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor + scoreboard ----------------
  initial begin : monitor
    logic [N-1:0]             prev_req, prev_we;
    logic [N-1:0][ADDR_W-1:0] prev_addr;
    logic [N-1:0][DATA_W-1:0] prev_wr;
    logic                     prev_mdone;
    logic [15:0]              e;
    logic [DATA_W-1:0]        d, exp_rd;
    int cyc, last_done_cyc, w, idx, ew;
    prev_req = '0; prev_we = '0; prev_addr = '0; prev_wr = '0; prev_mdone = 1'b0;
    cyc = 0; last_done_cyc = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetN) begin
        exp_q.delete();
        m_ptr = 0;
        model_read = '0;
        last_done_cyc = -100;
      end else begin
        if (m_req) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && prev_req[idx]) w = idx;
          end
          check("m_req_has_winner", 32'(w >= 0), 32'd1);
          if (w >= 0) begin
            check("grant_id", 32'(grant_id), 32'(w));
            check("m_addr", 32'(m_addr), 32'(prev_addr[w]));
            check("m_we", 32'(m_we), 32'(prev_we[w]));
            check("m_write", 32'(m_write), 32'(prev_wr[w]));
            check("grant_gap_ge2", 32'((cyc - last_done_cyc) >= 2), 32'd1);
            d = (force_rd >= 0) ? DATA_W'(force_rd) : DATA_W'($urandom);
            miu_data = d;
            miu_lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
            exp_q.push_back({3'b000, 4'(w), prev_we[w], d});
            grant_log.push_back(w);
          end
        end
        if (rq_done != '0) begin
          if (exp_q.size() == 0) begin
            check("rq_done_expected", 32'(rq_done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            ew = int'(e[12:9]);
            exp_rd = e[8] ? model_read : e[7:0];
            check("rq_done_onehot", 32'(rq_done), 32'(1) << ew);
            check("done_after_m_done", 32'(prev_mdone), 32'd1);
            check("rq_read", 32'(rq_read), 32'(exp_rd));
            model_read = exp_rd;
            m_ptr = (ew + 1) % N;
            last_done_cyc = cyc;
          end
        end
      end
      prev_req = rq_req; prev_we = rq_we; prev_addr = rq_addr; prev_wr = rq_write;
      prev_mdone = m_done;
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (rq_req == '0) && !busy;
      for (int i = 0; i < N; i++) if (issued[i] != target[i]) ok = 1'b0;
    end
    check({name, "_idle_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_mreq(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = m_req;
    end
    check({name, "_m_req_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rq_done"}, 32'(rq_done), 32'd0);
    check({name, "_rq_read"}, 32'(rq_read), 32'd0);
    check({name, "_m_req"}, 32'(m_req), 32'd0);
    check({name, "_m_we"}, 32'(m_we), 32'd0);
    check({name, "_m_addr"}, 32'(m_addr), 32'd0);
    check({name, "_m_write"}, 32'(m_write), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  task automatic set_next(input int i, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
    nx_we[i] = we;
    nx_addr[i] = a;
    nx_wr[i] = wd;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int g0;
    int exp_order[4];
    logic [N-1:0] any_done;
    for (int i = 0; i < N; i++) target[i] = 0;
    nx_we = '0; nx_addr = '0; nx_wr = '0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Single load from requester 1.
    force_rd = 8'hA5;
    set_next(1, 1'b0, 16'h0010, 8'h00);
    g0 = grant_log.size();
    target[1]++;
    wait_idle("t1", 200);
    check("t1_rq_read", 32'(rq_read), 32'hA5);
    check("t1_grants", 32'(grant_log.size() - g0), 32'd1);

    // Simultaneous requests from reset.
    reset_dut();
    force_rd = -1;
    for (int i = 0; i < N; i++) begin
      set_next(i, 1'b0, ADDR_W'(16'h0040 + i), DATA_W'(i));
      target[i] += 2;
    end
    g0 = grant_log.size();
    wait_idle("t2", 400);
    exp_order = '{0, 1, 2, 0};
    for (int k = 0; k < 4; k++) check($sformatf("t2_order_%0d", k), 32'(grant_log[g0 + k]), 32'(exp_order[k]));

    // Rotation: serve 2 alone, then 0 and 2 together.
    g0 = grant_log.size();
    target[2]++;
    wait_idle("t3a", 200);
    target[0]++;
    target[2]++;
    wait_idle("t3b", 200);
    check("t3_first", 32'(grant_log[g0]), 32'd2);
    check("t3_second", 32'(grant_log[g0 + 1]), 32'd0);
    check("t3_third", 32'(grant_log[g0 + 2]), 32'd2);

    // Store leaves rq_read unchanged.
    force_rd = 8'hA5;
    set_next(1, 1'b0, 16'h0030, 8'h00);
    target[1]++;
    wait_idle("t4a", 200);
    force_rd = 8'h5A;
    set_next(0, 1'b1, 16'h0022, 8'h3C);
    target[0]++;
    wait_idle("t4b", 200);
    check("t4_rq_read_kept", 32'(rq_read), 32'hA5);

    // Reset while the MIU response is pending.
    force_lat = 5;
    set_next(2, 1'b1, 16'h0044, 8'h77);
    target[2]++;
    wait_mreq("t5");
    repeat (2) @(negedge clk);
    reset_dut();
    @(negedge clk);
    check_reset_outputs("t5_reset");
    any_done = '0;
    repeat (10) begin
      @(negedge clk);
      any_done |= rq_done;
    end
    check("t5_no_done", 32'(any_done), 32'd0);
    force_lat = -1;
    force_rd = -1;
    set_next(1, 1'b0, 16'h0050, 8'h00);
    g0 = grant_log.size();
    target[1]++;
    wait_idle("t5b", 200);
    check("t5_served", 32'(grant_log[g0]), 32'd1);

    // Late arrival of requester 2 during requester 0's WAIT.
    force_lat = 4;
    set_next(0, 1'b0, 16'h0060, 8'h00);
    set_next(2, 1'b0, 16'h0062, 8'h00);
    g0 = grant_log.size();
    target[0]++;
    wait_mreq("t6");
    repeat (2) @(negedge clk);
    target[2]++;
    wait_idle("t6", 200);
    check("t6_first", 32'(grant_log[g0]), 32'd0);
    check("t6_second", 32'(grant_log[g0 + 1]), 32'd2);

    // Randomized traffic with field scrambling after grant.
    force_lat = -1;
    force_rd = -1;
    rand_fields = 1'b1;
    scramble = 1'b1;
    raise_pct = 30;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) target[i] += int'($urandom_range(0, 3));
      wait_idle("rand", 2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
